// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Write-side master of the double-buffered 4-bit grayscale framebuffer BRAM.
//   Pixels (x, y, data) arrive over a valid/ready handshake. They pass through a
//   short pipeline that turns coordinates into a linear address inside the back
//   buffer. The back buffer swaps as soon as a full frame of in-range pixels
//   has been accepted. A clear sweep fills the back buffer with CLEAR_VALUE. It
//   runs after reset and again when clear_in is pulsed.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   pix_valid_in/ready_out  pixel handshake; ready only in RUN
//   pix_x_in, pix_y_in      pixel coordinates (16 bit)
//   pix_data_in             grayscale value
//   clear_in                one-cycle request to clear the back buffer
//   wr_en/addr/data_out     BRAM write port (registered)
//   buf_sel_out             buffer being written; display reads the other one
//   frame_done_out          pulse that coincides with the write of a frame's last pixel
//   busy_out                high while draining or clearing
module framebuffer_writer #(
    parameter int         WIDTH       = 320,
    parameter int         HEIGHT      = 240,
    parameter int         ADDR_BITS   = 18,
    parameter logic [3:0] CLEAR_VALUE = 4'h0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 pix_valid_in,
    output logic                 pix_ready_out,
    input  logic [15:0]          pix_x_in,
    input  logic [15:0]          pix_y_in,
    input  logic [3:0]           pix_data_in,
    input  logic                 clear_in,
    output logic                 wr_en_out,
    output logic [ADDR_BITS-1:0] wr_addr_out,
    output logic [3:0]           wr_data_out,
    output logic                 buf_sel_out,
    output logic                 frame_done_out,
    output logic                 busy_out
);

    localparam int                   NPIX    = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] NPIX_A  = ADDR_BITS'(NPIX);
    localparam logic [ADDR_BITS-1:0] LAST_A  = ADDR_BITS'(NPIX - 1);
    localparam logic [ADDR_BITS-1:0] WIDTH_A = ADDR_BITS'(WIDTH);
    localparam int                   STAGES  = 2;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

    // stage 1: raw capture at the accept edge
    typedef struct packed {
        logic [15:0]          x;
        logic [15:0]          y;
        logic [3:0]           data;
        logic                 inr;
        logic                 last;
        logic [ADDR_BITS-1:0] base;
    } s1_t;

    // stage 2: row product already folded with the buffer base
    typedef struct packed {
        logic [ADDR_BITS-1:0] prod;
        logic [ADDR_BITS-1:0] x;
        logic [3:0]           data;
        logic                 inr;
        logic                 last;
    } s2_t;

    state_t               state, state_nxt;
    logic [STAGES:1]      vld_pipe;
    s1_t                  s1;
    s2_t                  s2;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] clr_idx;
    logic [ADDR_BITS-1:0] base_cur;
    logic                 accept;
    logic                 inr_in;

    assign base_cur = buf_sel_out ? NPIX_A : '0;
    assign accept   = pix_ready_out && pix_valid_in;
    assign inr_in   = (32'(pix_x_in) < 32'(WIDTH)) && (32'(pix_y_in) < 32'(HEIGHT));

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        pix_ready_out = 1'b0;
        busy_out      = 1'b1;
        case (state)
            ST_RUN: begin
                pix_ready_out = 1'b1;
                busy_out      = 1'b0;
                if (clear_in) state_nxt = ST_DRAIN;
            end
            // Let in-flight pixels finish so the sweep owns the write port alone.
            ST_DRAIN: if (vld_pipe == '0) state_nxt = ST_CLEAR;
            ST_CLEAR: if (!clear_in && clr_idx == LAST_A) state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe       <= '0;
            s1             <= '0;
            s2             <= '0;
            cnt            <= '0;
            clr_idx        <= '0;
            buf_sel_out    <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], accept};

            if (accept) begin
                s1.x    <= pix_x_in;
                s1.y    <= pix_y_in;
                s1.data <= pix_data_in;
                s1.inr  <= inr_in;
                s1.last <= inr_in && (cnt == LAST_A);
                s1.base <= base_cur;
                // Swap at capture so the very next pixel lands in the new buffer.
                if (inr_in) begin
                    if (cnt == LAST_A) begin
                        cnt         <= '0;
                        buf_sel_out <= ~buf_sel_out;
                    end else begin
                        cnt <= cnt + ADDR_BITS'(1);
                    end
                end
            end

            if (vld_pipe[1]) begin
                s2.prod <= ADDR_BITS'(s1.y) * WIDTH_A + s1.base;
                s2.x    <= ADDR_BITS'(s1.x);
                s2.data <= s1.data;
                s2.inr  <= s1.inr;
                s2.last <= s1.last;
            end

            if (state == ST_CLEAR) begin
                wr_en_out      <= 1'b1;
                wr_data_out    <= CLEAR_VALUE;
                frame_done_out <= 1'b0;
                if (clear_in) begin
                    // restart: this edge writes index 0 again
                    wr_addr_out <= base_cur;
                    clr_idx     <= (LAST_A == '0) ? '0 : ADDR_BITS'(1);
                end else begin
                    wr_addr_out <= base_cur + clr_idx;
                    if (clr_idx == LAST_A) begin
                        clr_idx <= '0;
                        cnt     <= '0;
                    end else begin
                        clr_idx <= clr_idx + ADDR_BITS'(1);
                    end
                end
            end else begin
                // out-of-range pixels flow through but never assert the write
                wr_en_out      <= vld_pipe[2] && s2.inr;
                frame_done_out <= vld_pipe[2] && s2.last;
                if (vld_pipe[2]) begin
                    wr_addr_out <= s2.prod + s2.x;
                    wr_data_out <= s2.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer at WIDTH=4, HEIGHT=2. The reference model keeps
// the buffer select and the frame pixel count. It predicts each BRAM write as an
// address/data/done entry in a queue, and a negedge monitor compares every
// write against that queue.
module tb_framebuffer_writer;

    localparam int         W   = 4;
    localparam int         H   = 2;
    localparam int         AB  = 6;
    localparam logic [3:0] CLR = 4'h0;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           pix_valid_in;
    logic           pix_ready_out;
    logic [15:0]    pix_x_in, pix_y_in;
    logic [3:0]     pix_data_in;
    logic           clear_in;
    logic           wr_en_out;
    logic [AB-1:0]  wr_addr_out;
    logic [3:0]     wr_data_out;
    logic           buf_sel_out, frame_done_out, busy_out;

    framebuffer_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_BITS(AB), .CLEAR_VALUE(CLR)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .pix_valid_in(pix_valid_in), .pix_ready_out(pix_ready_out),
        .pix_x_in(pix_x_in), .pix_y_in(pix_y_in), .pix_data_in(pix_data_in),
        .clear_in(clear_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .buf_sel_out(buf_sel_out), .frame_done_out(frame_done_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int addr;
        int data;
        int done;
        int cyc;   // negedge cycle the write must appear in; -1 = any
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    int  m_buf = 0;
    int  m_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin : mon
        wr_t e;
        if (wr_en_out === 1'b1) begin
            if (q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_addr_out), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(wr_addr_out), 32'(e.addr));
                chk("wr_data", 32'(wr_data_out), 32'(e.data));
                chk("wr_done", 32'(frame_done_out), 32'(e.done));
                if (e.cyc >= 0) chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("done_idle", 32'(frame_done_out), 32'd0);
        end
        chk("buf_sel", 32'(buf_sel_out), 32'(m_buf));
    end

    // model: one accepted pixel
    task automatic model_accept(input int x, input int y, input int d);
        int last;
        if (x < W && y < H) begin
            last = (m_cnt == W * H - 1) ? 1 : 0;
            q.push_back('{addr: m_buf * W * H + y * W + x, data: d, done: last, cyc: cyc + 2});
            if (last != 0) begin
                m_cnt = 0;
                m_buf ^= 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic model_clear(input int first_cyc);
        for (int i = 0; i < W * H; i++)
            q.push_back('{addr: m_buf * W * H + i, data: int'(CLR), done: 0,
                          cyc: (first_cyc < 0) ? -1 : first_cyc + i});
        m_cnt = 0;
    endtask

    // Called at posedge+1. Offers one pixel, optionally with clear_in.
    task automatic send(input int x, input int y, input int d, input bit clr);
        pix_valid_in = 1'b1;
        pix_x_in     = 16'(x);
        pix_y_in     = 16'(y);
        pix_data_in  = 4'(d);
        clear_in     = clr;
        @(negedge clk_in);
        chk("ready", 32'(pix_ready_out), 32'd1);
        @(posedge clk_in); #1;
        pix_valid_in = 1'b0;
        clear_in     = 1'b0;
        model_accept(x, y, d);
        if (clr) model_clear(-1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_run(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_in);
            if (pix_ready_out === 1'b1) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        @(posedge clk_in); #1;
    endtask

    // Called at posedge+1 while in reset.
    task automatic release_reset();
        rst_in = 1'b0;
        m_buf  = 0;
        model_clear(cyc + 1);
    endtask

    initial begin
        bit hit;
        rst_in = 1'b1; pix_valid_in = 1'b0; pix_x_in = '0; pix_y_in = '0;
        pix_data_in = '0; clear_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_wr_en",   32'(wr_en_out),      32'd0);
        chk("rst_addr",    32'(wr_addr_out),    32'd0);
        chk("rst_data",    32'(wr_data_out),    32'd0);
        chk("rst_done",    32'(frame_done_out), 32'd0);
        chk("rst_ready",   32'(pix_ready_out),  32'd0);
        chk("rst_busy",    32'(busy_out),       32'd1);
        @(posedge clk_in); #1;

        // post-reset sweep: addr 0..7 on the 8 edges after release
        release_reset();
        repeat (7) @(negedge clk_in);
        chk("sweep_busy",  32'(busy_out),      32'd1);
        chk("sweep_ready", 32'(pix_ready_out), 32'd0);
        repeat (2) @(negedge clk_in);
        chk("run_ready",   32'(pix_ready_out), 32'd1);
        chk("run_busy",    32'(busy_out),      32'd0);
        @(posedge clk_in); #1;

        // latency/address
        send(3, 1, 4'hA, 1'b0);
        repeat (3) @(negedge clk_in);
        chk("lat_wr_en", 32'(wr_en_out),   32'd1);
        chk("lat_addr",  32'(wr_addr_out), 32'd7);
        chk("lat_data",  32'(wr_data_out), 32'hA);
        @(negedge clk_in);
        chk("lat_after", 32'(wr_en_out),   32'd0);
        @(posedge clk_in); #1;

        // random back-to-back stream with out-of-range and duplicate coordinates
        for (int i = 0; i < 24; i++)
            send($urandom_range(0, W + 1), $urandom_range(0, H), $urandom_range(0, 15), 1'b0);
        idle(4);

        // reach buffer 1 at count 0, then clear with two pixels in flight
        for (int i = 0; i < 16 && !(m_buf == 1 && m_cnt == 0); i++)
            send($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 15), 1'b0);
        chk("setup_buf1", 32'(m_buf), 32'd1);
        send(1, 0, 4'h5, 1'b0);
        send(2, 1, 4'h9, 1'b1);
        @(negedge clk_in);
        chk("drain_ready", 32'(pix_ready_out), 32'd0);
        chk("drain_busy",  32'(busy_out),      32'd1);
        wait_run("clear_done");

        // count restarted: a full frame of 8 in-range pixels, done on the last
        for (int i = 0; i < W * H; i++)
            send(i % W, i / W, $urandom_range(0, 15), 1'b0);
        idle(4);

        // back to buffer 1, clear, then reset during sweep index 3
        for (int i = 0; i < 16 && !(m_buf == 1 && m_cnt == 0); i++)
            send($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 15), 1'b0);
        idle(3);
        clear_in = 1'b1;
        @(posedge clk_in); #1;
        clear_in = 1'b0;
        model_clear(-1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk_in);
            if (wr_en_out === 1'b1 && int'(wr_addr_out) == m_buf * W * H + 3) hit = 1'b1;
        end
        chk("midclear_idx3", 32'(hit), 32'd1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        q.delete();
        m_buf = 0;
        m_cnt = 0;
        @(negedge clk_in);
        chk("midclear_wr_en", 32'(wr_en_out),   32'd0);
        chk("midclear_buf",   32'(buf_sel_out), 32'd0);
        @(posedge clk_in); #1;
        release_reset();
        wait_run("resweep_done");

        // a few more pixels, then everything predicted must have been written
        for (int i = 0; i < 10; i++)
            send($urandom_range(0, W + 1), $urandom_range(0, H), $urandom_range(0, 15), 1'b0);
        idle(5);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Write-side master of the 4-bit grayscale framebuffer BRAM. The VGA display reads the same BRAM on its other port.
- Accepts (x, y, pixel) writes from the ray marcher over a valid/ready handshake and converts each one to a linear BRAM address.
- Double-buffers the BRAM: all writes go to the back buffer, and the buffers swap once a full frame of pixels has been accepted.
- Provides a hardware clear sweep, run automatically after reset and on request.

Parameters:
- WIDTH, 320, framebuffer width in pixels (matches `DISPLAY_WIDTH).
- HEIGHT, 240, framebuffer height in pixels.
- ADDR_BITS, 18, BRAM address width; must hold 2*WIDTH*HEIGHT.
- CLEAR_VALUE, 4'h0, grayscale value written during a clear sweep.

Ports:
- clk_in  input  1  system clock (single domain)
- rst_in  input  1  synchronous active-high reset
- pix_valid_in  input  1  pixel write request
- pix_ready_out  output  1  writer can accept a pixel this cycle
- pix_x_in  input  16  pixel column
- pix_y_in  input  16  pixel row
- pix_data_in  input  4  grayscale value
- clear_in  input  1  one-cycle request to clear the back buffer
- wr_en_out  output  1  BRAM write enable
- wr_addr_out  output  ADDR_BITS  BRAM write address
- wr_data_out  output  4  BRAM write data
- buf_sel_out  output  1  back buffer currently being written; display reads ~buf_sel_out
- frame_done_out  output  1  one-cycle pulse coincident with the write of a frame's last pixel
- busy_out  output  1  high while in CLEAR or DRAIN

Behaviour:
- Clock and reset: single clock clk_in; rst_in is synchronous, active-high.
- Reset values:
  - State = CLEAR, sweep index 0, pixel count 0, pipeline empty.
  - wr_en_out=0, wr_addr_out=0, wr_data_out=0, buf_sel_out=0, frame_done_out=0.
  - pix_ready_out=0, busy_out=1.
  - A reset mid-sweep or mid-pipeline discards all in-flight work.
- Base address: BASE = buf_sel ? WIDTH*HEIGHT : 0.
- States:
  - RUN: pix_ready_out=1. A pixel is accepted on any edge where valid && ready.
  - DRAIN: entered from RUN when clear_in is sampled. pix_ready_out=0. Stays until both pipeline stages are empty (at most 2 cycles), then goes to CLEAR.
  - CLEAR: pix_ready_out=0. Writes CLEAR_VALUE to BASE+i for i = 0..WIDTH*HEIGHT-1, one per cycle. After the edge that writes the last index, goes to RUN with pixel count = 0. buf_sel is unchanged.
- Pixel pipeline:
  - Stage 1 captures at the accepting edge k:
    - x, y, data, and the in-range flag (x<WIDTH && y<HEIGHT).
    - BASE as it is at capture time.
    - A last flag = (in-range && count==WIDTH*HEIGHT-1).
  - Stage 2 (edge k+1): product y*WIDTH + BASE.
  - Stage 3 (edge k+2): wr_addr_out = product + x, wr_data_out = data, wr_en_out = in-range, frame_done_out = last.
  - Write outputs are therefore valid in the cycle after edge k+2 (latency 2). Throughput is 1 pixel/cycle with no backpressure from the BRAM.
- Out-of-range pixels are accepted, never written, and not counted. Only the ready handshake reflects them.
- Pixel counter:
  - Increments at stage-1 capture of each in-range pixel.
  - On capture of the last pixel: count resets to 0 and buf_sel toggles at that same edge, so the next accepted pixel is based on the new buffer.
  - Duplicate coordinates within a frame still count.
- Clear behaviour:
  - clear_in in CLEAR restarts the sweep at index 0.
  - clear_in in DRAIN is ignored.
  - clear_in simultaneous with an accepted pixel: the pixel is accepted and written, then DRAIN.
  - Clear writes use the same output registers: wr_en_out=1, data=CLEAR_VALUE, frame_done_out=0.
- Write-port ownership: pipeline writes and sweep writes never overlap, because DRAIN guarantees exclusivity.
- Widths: product computed at ADDR_BITS bits with no truncation for legal parameters. Coordinate compares use the full 16 bits.

Test Plan:
- Post-reset clear (WIDTH=4, HEIGHT=2, CLEAR_VALUE=4'h0): deassert rst_in -> wr_en high for exactly 8 cycles with addr 0..7 and data 0; busy_out drops and pix_ready_out rises the next cycle; buf_sel_out=0.
- Latency and address: after the clear, accept (x=3, y=1, d=4'hA) at edge k -> cycle after edge k+2 shows wr_en=1, addr=7, data=A; wr_en=0 the following cycle when no further pixel is offered.
- Frame swap: stream all 8 in-range pixels back-to-back -> frame_done_out pulses together with the write of the 8th pixel; buf_sel_out reads 1 after the 8th accept edge; the next pixel (0,0) writes addr 8.
- Out-of-range: offer (x=4, y=0) and (x=0, y=2) -> both handshakes complete, no write issued, frame count unchanged (frame_done still requires 8 in-range pixels).
- Clear mid-stream: assert clear_in with 2 pixels in flight -> both pixels are written, pix_ready_out is low during DRAIN, then 8 clear writes go to buffer base (addr 8..15 when buf_sel=1); count is 0 afterwards.
- Reset mid-clear: assert rst_in during sweep index 3 -> next cycle wr_en=0 and buf_sel=0; the sweep restarts from addr 0 after release.
